// File: rtl/wash_timer.sv
// Wash/spin stage timer: prescaled tick counter with registered timeout flags.
// Optional WASH_TIMER_PAUSE_EN adds a pause input that freezes an active stage.
module wash_timer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wash_run,
    input  logic       spin_run,
    input  logic       clear,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [7:0] cycle_len,
    input  logic [7:0] spin_len,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic       busy,
    output logic [7:0] remaining
);

    localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WASH     = 3'b001,
        SPIN     = 3'b010,
        EXP_WASH = 3'b011,
        EXP_SPIN = 3'b100
    } state_t;

    state_t     state;
    logic [7:0] counter;
    logic [7:0] prescaler;
    logic       paused;
    logic       run_req;

`ifdef WASH_TIMER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        run_req = (state == SPIN) ? spin_run : wash_run;
    end

    function automatic logic [7:0] nonzero_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            counter       <= '0;
            prescaler     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            busy          <= 1'b0;
            remaining     <= '0;
        end else if (clear) begin
            state         <= IDLE;
            counter       <= '0;
            prescaler     <= '0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            busy          <= 1'b0;
            remaining     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    prescaler     <= '0;
                    cycle_timeout <= 1'b0;
                    spin_timeout  <= 1'b0;
                    if (wash_run) begin
                        state     <= WASH;
                        counter   <= nonzero_len(cycle_len);
                        remaining <= nonzero_len(cycle_len);
                        busy      <= 1'b1;
                    end else if (spin_run) begin
                        state     <= SPIN;
                        counter   <= nonzero_len(spin_len);
                        remaining <= nonzero_len(spin_len);
                        busy      <= 1'b1;
                    end else begin
                        counter   <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                    end
                end

                WASH, SPIN: begin
                    if (!run_req) begin
                        state     <= IDLE;
                        counter   <= '0;
                        prescaler <= '0;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (!paused) begin
                        if (prescaler == PRE_LAST) begin
                            prescaler <= '0;
                            // Final tick: expire instead of decrementing to zero.
                            if (counter == 8'd1) begin
                                state         <= (state == WASH) ? EXP_WASH : EXP_SPIN;
                                counter       <= '0;
                                busy          <= 1'b0;
                                remaining     <= '0;
                                cycle_timeout <= (state == WASH);
                                spin_timeout  <= (state == SPIN);
                            end else begin
                                counter   <= counter - 8'd1;
                                remaining <= counter - 8'd1;
                            end
                        end else begin
                            prescaler <= prescaler + 8'd1;
                        end
                    end
                end

                EXP_WASH: begin
                    if (!wash_run) begin
                        state         <= IDLE;
                        cycle_timeout <= 1'b0;
                    end
                end

                EXP_SPIN: begin
                    if (!spin_run) begin
                        state        <= IDLE;
                        spin_timeout <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    counter       <= '0;
                    prescaler     <= '0;
                    cycle_timeout <= 1'b0;
                    spin_timeout  <= 1'b0;
                    busy          <= 1'b0;
                    remaining     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_timer.sv
// Bench for wash_timer: directed scenarios plus randomized stimulus against an
// elapsed-time model of the stage timer.
module tb_wash_timer;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       wash_run;
    logic       spin_run;
    logic       clear;
    logic       pause;
    logic [7:0] cycle_len;
    logic [7:0] spin_len;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       busy;
    logic [7:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    wash_timer #(.TICK_DIV(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .wash_run     (wash_run),
        .spin_run     (spin_run),
        .clear        (clear),
`ifdef WASH_TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .cycle_len    (cycle_len),
        .spin_len     (spin_len),
        .cycle_timeout(cycle_timeout),
        .spin_timeout (spin_timeout),
        .busy         (busy),
        .remaining    (remaining)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a stage is a run of non-paused edges; it expires once
    // len*D such edges have elapsed since entry.
    bit m_active, m_spin, m_expired;
    int m_len, m_elapsed;

    always @(posedge clk or negedge reset) begin
        bit p, run;
`ifdef WASH_TIMER_PAUSE_EN
        p = pause;
`else
        p = 0;
`endif
        if (!reset || clear) begin
            m_active = 0;
        end else if (!m_active) begin
            if (wash_run || spin_run) begin
                m_active  = 1;
                m_spin    = !wash_run;
                m_len     = m_spin ? int'(spin_len) : int'(cycle_len);
                if (m_len == 0) m_len = 1;
                m_elapsed = 0;
                m_expired = 0;
            end
        end else begin
            run = m_spin ? spin_run : wash_run;
            if (!run) m_active = 0;
            else if (!m_expired && !p) begin
                m_elapsed++;
                if (m_elapsed == m_len * D) m_expired = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit in_stage;
            in_stage = m_active && !m_expired;
            check("busy", int'(busy), int'(in_stage));
            check("cycle_timeout", int'(cycle_timeout), int'(m_active && m_expired && !m_spin));
            check("spin_timeout", int'(spin_timeout), int'(m_active && m_expired && m_spin));
            check("remaining", int'(remaining), in_stage ? (m_len - m_elapsed / D) : 0);
            check("timeouts_exclusive", int'(cycle_timeout & spin_timeout), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wash_run = 0; spin_run = 0; clear = 0; pause = 0;
    endtask

    // Counts edges until the selected timeout rises; 200 means it never did.
    task automatic count_to_timeout(input bit spin, output int edges);
        edges = 0;
        while (edges < 200) begin
            tick();
            edges++;
            if (spin ? spin_timeout : cycle_timeout) break;
        end
        if (edges == 200) edges = 200;
    endtask

    initial begin
        int edges;
        int rem_at[0:15];
        reset = 0;
        idle_inputs();
        cycle_len = 0; spin_len = 0;
        #1;
        tick(); tick();
        check("reset_busy", int'(busy), 0);
        check("reset_remaining", int'(remaining), 0);
        check("reset_timeouts", int'(cycle_timeout | spin_timeout), 0);
        reset = 1;
        chk_en = 1;
        tick();

        // wash of 3 ticks, held until wash_run drops
        cycle_len = 3; wash_run = 1;
        tick();
        check("w3_entry_busy", int'(busy), 1);
        check("w3_entry_rem", int'(remaining), 3);
        edges = 0;
        while (edges < 200) begin
            tick();
            edges++;
            if (edges < 16) rem_at[edges] = int'(remaining);
            if (cycle_timeout) break;
        end
        check("w3_timeout_edges", edges, 12);
        check("w3_rem_e3", rem_at[3], 3);
        check("w3_rem_e4", rem_at[4], 2);
        check("w3_rem_e8", rem_at[8], 1);
        tick(); tick(); tick();
        check("w3_hold", int'(cycle_timeout), 1);
        wash_run = 0;
        tick();
        check("w3_release", int'(cycle_timeout), 0);
        tick();

        // zero-length spin loads as one tick
        spin_len = 0; spin_run = 1;
        tick();
        check("s0_entry_rem", int'(remaining), 1);
        count_to_timeout(1, edges);
        check("s0_timeout_edges", edges, 4);
        spin_run = 0;
        tick(); tick();

        // both requests together: wash wins
        cycle_len = 2; spin_len = 7; wash_run = 1; spin_run = 1;
        tick();
        count_to_timeout(0, edges);
        check("both_timeout_edges", edges, 8);
        check("both_no_spin_to", int'(spin_timeout), 0);
        wash_run = 0; spin_run = 0;
        tick(); tick();

        // abort mid-wash
        cycle_len = 5; wash_run = 1;
        tick();
        repeat (6) tick();
        check("abort_rem_before", int'(remaining), 4);
        wash_run = 0;
        tick();
        check("abort_rem", int'(remaining), 0);
        check("abort_busy", int'(busy), 0);
        repeat (30) tick();
        check("abort_no_timeout", int'(cycle_timeout), 0);

        // reset mid-spin, then a fresh spin
        spin_len = 4; spin_run = 1;
        tick();
        repeat (10) tick();
        reset = 0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_to", int'(cycle_timeout | spin_timeout), 0);
        tick(); tick();
        reset = 1;
        tick();
        count_to_timeout(1, edges);
        check("rst_fresh_spin_edges", edges, 16);
        spin_run = 0;
        tick();

        // clear overrides an active wash
        cycle_len = 9; wash_run = 1;
        tick(); repeat (5) tick();
        clear = 1;
        tick();
        check("clear_busy", int'(busy), 0);
        check("clear_rem", int'(remaining), 0);
        clear = 0; wash_run = 0;
        tick();

`ifdef WASH_TIMER_PAUSE_EN
        cycle_len = 2; wash_run = 1;
        tick();
        repeat (3) tick();
        pause = 1;
        repeat (5) tick();
        pause = 0;
        edges = 8;
        while (edges < 200) begin
            tick();
            edges++;
            if (cycle_timeout) break;
        end
        check("pause_timeout_edges", edges, 13);
        wash_run = 0;
        tick(); tick();
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) wash_run = ~wash_run;
            if ($urandom_range(0, 14) == 0) spin_run = ~spin_run;
            clear     = ($urandom_range(0, 99) == 0);
            cycle_len = 8'($urandom_range(0, 5));
            spin_len  = 8'($urandom_range(0, 5));
`ifdef WASH_TIMER_PAUSE_EN
            pause     = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                tick();
                reset = 1;
            end
            tick();
        end

        idle_inputs();
        tick(); tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_timer.md
WASH_TIMER -- requirements
Module: wash_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clocks per timer tick (legal range 2..256).
REQ-002 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-003 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: wash_run  input  1  wash-stage request, driven by the washer controller's motor_on.
REQ-005 SHALL have: spin_run  input  1  spin-stage request from the washer controller.
REQ-006 SHALL have: clear  input  1  synchronous abort, returns to IDLE.
REQ-007 SHALL have: cycle_len  input  8  wash duration in ticks, sampled on WASH entry.
REQ-008 SHALL have: spin_len  input  8  spin duration in ticks, sampled on SPIN entry.
REQ-009 SHALL have: cycle_timeout  output  1  wash expired, feeds washer controller.
REQ-010 SHALL have: spin_timeout  output  1  spin expired, feeds washer controller.
REQ-011 SHALL have: busy  output  1  high in WASH or SPIN.
REQ-012 SHALL have: remaining  output  8  ticks left in the active stage.

Function
REQ-013 SHALL implement states IDLE=000, WASH=001, SPIN=010, EXP_WASH=011, EXP_SPIN=100; all outputs registered.
REQ-014 IDLE: wash_run=1 -> WASH, load counter=cycle_len; else spin_run=1 -> SPIN, load counter=spin_len; wash_run wins if both high.
REQ-015 A length of 0 SHALL be loaded as 1.
REQ-016 On WASH/SPIN entry the prescaler SHALL clear to 0; it counts 0..TICK_DIV-1, tick when prescaler==TICK_DIV-1, then wraps to 0.
REQ-017 On each tick in WASH/SPIN the counter SHALL decrement; tick with counter==1 -> EXP_WASH/EXP_SPIN.
REQ-018 Timeout SHALL be asserted exactly length*TICK_DIV clock edges after the edge entering WASH/SPIN.
REQ-019 WASH with wash_run=0, or SPIN with spin_run=0, SHALL go to IDLE next edge without any timeout (abort).
REQ-020 EXP_WASH SHALL hold cycle_timeout=1 until wash_run=0, then IDLE; EXP_SPIN likewise for spin_timeout/spin_run.
REQ-021 cycle_timeout and spin_timeout SHALL never be high together; busy=0 in EXP_* and IDLE.
REQ-022 remaining SHALL equal the counter in WASH/SPIN and 0 in all other states.
REQ-023 clear=1 SHALL force IDLE, counter 0, prescaler 0, all outputs 0 on next edge, overriding every other input.
REQ-024 Illegal state encodings SHALL return to IDLE on next edge.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, counter=0, prescaler=0, cycle_timeout=0, spin_timeout=0, busy=0, remaining=0.
REQ-026 Reset asserted mid-WASH/SPIN SHALL discard the stage; after release the block waits in IDLE for a new run request.

Configuration
REQ-027 Macro WASH_TIMER_PAUSE_EN defined SHALL add input pause (1 bit); pause=1 in WASH/SPIN freezes prescaler and counter, state and outputs held; abort and clear still take effect.
REQ-028 Without WASH_TIMER_PAUSE_EN the pause port SHALL not exist and timing is as if pause=0.

Verification
REQ-029 TICK_DIV=4, cycle_len=3, wash_run held high -> WASH entered, remaining 3,2,1, cycle_timeout high 12 edges after entry, held until wash_run drops, then IDLE.
REQ-030 spin_len=0, spin_run high -> SPIN loads 1, spin_timeout high 4 edges after entry.
REQ-031 wash_run and spin_run rise together, cycle_len=2 -> WASH chosen, only cycle_timeout asserts, after 8 edges.
REQ-032 cycle_len=5, wash_run dropped after 6 edges in WASH -> IDLE, cycle_timeout never asserts, remaining=0.
REQ-033 reset low 10 edges into a spin_len=4 SPIN -> all outputs 0 immediately; after release with spin_run high a fresh 16-edge SPIN runs.
REQ-034 With WASH_TIMER_PAUSE_EN, cycle_len=2, pause high 5 edges mid-WASH -> cycle_timeout asserts after 13 edges instead of 8.
